rr_arbiter_4: RTL and testbench



---
 rtl/rr_arbiter_4.sv | 125 ++++++++++++
 tb/tb_rr_arbiter_4.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a registered one-hot grant, hold-time timeout and an idle bubble between owners.
// Optional ARB_LOCK_EN adds a lock input that freezes the hold counter and suppresses timeout while granted.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_SAT = '1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    gnt_id_q, gnt_id_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic          preempt_q, preempt_d;

  logic          win_vld;
  logic [1:0]    win_id;
  logic [1:0]    idx;
  logic          lock_act;
  logic          timeout;

`ifdef ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  assign timeout = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_MAX) && !lock_act;

  // Scan from the farthest offset down so the requester nearest ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 2'd0;
    idx     = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d       = 4'b0000;
        gnt_id_d    = 2'd0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
        if (win_vld) begin
          state_d     = GRANT;
          gnt_d       = 4'b0001 << win_id;
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = CW'(1);
        end
      end
      GRANT: begin
        // Release takes priority over a coincident timeout, so no preempt pulse then.
        if (!req[gnt_id_q] || timeout) begin
          state_d     = IDLE;
          ptr_d       = gnt_id_q + 2'd1;
          hold_cnt_d  = '0;
          gnt_d       = 4'b0000;
          gnt_id_d    = 2'd0;
          gnt_valid_d = 1'b0;
          preempt_d   = req[gnt_id_q];
        end else if (!lock_act && hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      hold_cnt_q  <= '0;
      gnt_q       <= 4'b0000;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: table of per-cycle vectors plus hand sequences for timeout, hold/timeout collision and reset.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;
`ifdef ARB_LOCK_EN
  logic       lock = 1'b0;
`endif

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       vld;
    logic       pre;
    string      name;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    exp_t       exp;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t gr(input int id, input string nm);
    exp_t e;
    logic [3:0] oh;
    oh = 4'b0001 << id;
    e.gnt = oh; e.id = 2'(id); e.vld = 1'b1; e.pre = 1'b0; e.name = nm;
    return e;
  endfunction

  function automatic exp_t idle(input logic p, input string nm);
    exp_t e;
    e.gnt = 4'b0000; e.id = 2'd0; e.vld = 1'b0; e.pre = p; e.name = nm;
    return e;
  endfunction

  function automatic vec_t v(input logic [3:0] r, input exp_t e);
    vec_t x;
    x.req = r; x.exp = e;
    return x;
  endfunction

  task automatic check(input exp_t e);
    n_cmp++;
    if (gnt !== e.gnt || gnt_id !== e.id || gnt_valid !== e.vld || preempt !== e.pre) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b id=%0d vld=%b pre=%b, want gnt=%b id=%0d vld=%b pre=%b",
               e.name, gnt, gnt_id, gnt_valid, preempt, e.gnt, e.id, e.vld, e.pre);
    end
  endtask

  // Drive req for one cycle, queue what the outputs must be after the edge, then compare.
  task automatic step(input logic [3:0] r, input exp_t e);
    exp_t got;
    req = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
    end else begin
      got = sb.pop_front();
      check(got);
    end
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check(idle(1'b0, "reset_state"));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    do_reset();

    // Round robin from reset, then pointer wrap, then a single requester.
    tbl.push_back(v(4'b1111, gr(0, "rr0")));
    tbl.push_back(v(4'b1111, gr(0, "rr0_hold")));
    tbl.push_back(v(4'b1110, idle(0, "rr_gap0")));
    tbl.push_back(v(4'b1111, gr(1, "rr1")));
    tbl.push_back(v(4'b1111, gr(1, "rr1_hold")));
    tbl.push_back(v(4'b1101, idle(0, "rr_gap1")));
    tbl.push_back(v(4'b1111, gr(2, "rr2")));
    tbl.push_back(v(4'b1111, gr(2, "rr2_hold")));
    tbl.push_back(v(4'b1011, idle(0, "rr_gap2")));
    tbl.push_back(v(4'b1111, gr(3, "rr3")));
    tbl.push_back(v(4'b1111, gr(3, "rr3_hold")));
    tbl.push_back(v(4'b0111, idle(0, "rr_gap3")));
    tbl.push_back(v(4'b1111, gr(0, "rr0_again")));
    tbl.push_back(v(4'b0000, idle(0, "rr_end")));
    tbl.push_back(v(4'b0000, idle(0, "rr_idle")));
    tbl.push_back(v(4'b1001, gr(3, "wrap_ptr1_to3")));
    tbl.push_back(v(4'b0001, idle(0, "wrap_rel3")));
    tbl.push_back(v(4'b1001, gr(0, "wrap_3_to_0")));
    tbl.push_back(v(4'b1000, idle(0, "wrap_rel0")));
    tbl.push_back(v(4'b1001, gr(3, "wrap_0_to_3")));
    tbl.push_back(v(4'b0000, idle(0, "wrap_end")));
    tbl.push_back(v(4'b0000, idle(0, "wrap_idle")));
    tbl.push_back(v(4'b0100, gr(2, "single_gnt")));
    tbl.push_back(v(4'b0100, gr(2, "single_hold")));
    tbl.push_back(v(4'b0000, idle(0, "single_rel")));
    tbl.push_back(v(4'b0000, idle(0, "single_idle")));
    foreach (tbl[i]) step(tbl[i].req, tbl[i].exp);

    // Release coinciding with the last allowed hold cycle: no preempt.
    do_reset();
    for (int i = 0; i < 8; i++) step(4'b0100, gr(2, $sformatf("relto_hold%0d", i)));
    step(4'b0000, idle(0, "relto_no_preempt"));
    step(4'b0000, idle(0, "relto_idle"));

    // Timeout with two competitors held constantly.
    do_reset();
    for (int i = 0; i < 8; i++) step(4'b1010, gr(1, $sformatf("to_own1_%0d", i)));
    step(4'b1010, idle(1, "to_preempt1"));
    for (int i = 0; i < 8; i++) step(4'b1010, gr(3, $sformatf("to_own3_%0d", i)));
    step(4'b1010, idle(1, "to_preempt3"));
    step(4'b1010, gr(1, "to_back_to1"));
    step(4'b1010, gr(1, "to_back_to1_hold"));

    // Asynchronous reset while a grant is active.
    #3;
    req   = 4'b1111;
    rst_n = 1'b0;
    #1;
    check(idle(0, "async_reset_midgrant"));
    @(posedge clk);
    #1;
    check(idle(0, "reset_held"));
    req   = 4'b0000;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check(idle(0, "post_reset_idle"));
    step(4'b0000, idle(0, "post_reset_idle2"));
    step(4'b0010, gr(1, "post_reset_gnt"));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
